// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter in front of a shared UART transmitter
//
// Purpose:
//   Serialises byte requests from two requesters onto one uart_transmitter.
//   A grant is only issued while the transmitter is idle. The granted byte is
//   launched with a one-cycle send pulse. The arbiter then waits for the
//   transmitter's busy flag to rise and fall again, and completes the
//   transfer with a one-cycle ack to the owner. If busy never rises within
//   BUSY_TIMEOUT cycles, the launch is abandoned with a timeout pulse. The
//   request is left pending, so it is retried on the next grant.
//
// Parameters:
//   BUSY_TIMEOUT  cycles allowed for ut_busy to rise after a send (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req0/req1    per-requester request, held until the matching ack
//   data0/data1  per-requester byte, captured only at grant
//   ack0/ack1    one-cycle completion pulse to the owning requester
//   ut_data      byte presented to the transmitter
//   ut_send      one-cycle send trigger to the transmitter
//   ut_busy      transmitter busy flag
//   grant_id     index of the current or most recently granted requester
//   active       high whenever the arbiter is not idle
//   timeout_err  one-cycle pulse when the busy handshake times out

module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] ut_data,
    output logic       ut_send,
    input  logic       ut_busy,
    output logic       grant_id,
    output logic       active,
    output logic       timeout_err
);

    localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_winner;

    logic          w_grant;
    logic          w_pick;
    logic [CW-1:0] w_cnt_next;

    // A grant needs an idle transmitter and at least one pending request.
    assign w_grant    = (req0 | req1) & ~ut_busy;
    // Contention goes to the requester that did not complete last; otherwise
    // the only requester present wins (req1 alone -> 1, req0 alone -> 0).
    assign w_pick     = (req0 & req1) ? ~r_last_winner : req1;
    assign w_cnt_next = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_last_winner <= 1'b1;
            ut_data       <= 8'h00;
            ut_send       <= 1'b0;
            grant_id      <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            active        <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            // Pulse outputs default low so each one lasts exactly one cycle.
            ut_send     <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        ut_data  <= w_pick ? data1 : data0;
                        grant_id <= w_pick;
                        ut_send  <= 1'b1;
                        active   <= 1'b1;
                        r_state  <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (ut_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (w_cnt_next == TIMEOUT_LAST) begin
                        // Abandon the launch; last_winner is left alone so the
                        // same requester keeps its turn on the retry.
                        r_cnt       <= w_cnt_next;
                        timeout_err <= 1'b1;
                        active      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                S_WAIT_DONE: begin
                    if (!ut_busy) begin
                        ack0    <= ~grant_id;
                        ack1    <= grant_id;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_last_winner <= grant_id;
                    active        <= 1'b0;
                    r_state       <= S_IDLE;
                end

                default: begin
                    active  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have one parameter: BUSY_TIMEOUT, default 64, maximum cycles to wait for ut_busy to rise after a send pulse.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 wants one byte transmitted; held until ack0.
REQ-005 data0  input  8  requester 0 byte; sampled only at grant.
REQ-006 ack0  output  1  one-cycle pulse: requester 0 byte fully transmitted.
REQ-007 req1  input  1  requester 1 request; same rules as req0.
REQ-008 data1  input  8  requester 1 byte.
REQ-009 ack1  output  1  one-cycle completion pulse for requester 1.
REQ-010 ut_data  output  8  byte driven to the shared uart_transmitter data input.
REQ-011 ut_send  output  1  one-cycle send trigger to the uart_transmitter.
REQ-012 ut_busy  input  1  busy flag from the uart_transmitter.
REQ-013 grant_id  output  1  index of the current or last granted requester.
REQ-014 active  output  1  high in every state except IDLE.
REQ-015 timeout_err  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE; all outputs registered.
REQ-017 IDLE: the FSM SHALL grant only when ut_busy=0 and at least one req is high; otherwise it SHALL remain in IDLE.
REQ-018 Single request: the FSM SHALL grant that requester.
REQ-019 Both requests high: the FSM SHALL grant the requester other than last_winner (round-robin); last_winner resets to 1, so req0 wins first.
REQ-020 On grant: ut_data SHALL load the granted dataN, grant_id SHALL load N, and the next state SHALL be LAUNCH.
REQ-021 Send latency: a req seen in IDLE at edge k SHALL produce ut_send=1 in cycle k+1.
REQ-022 LAUNCH: ut_send SHALL be 1 for exactly this one cycle, the timeout counter SHALL clear, and the next state SHALL be WAIT_BUSY.
REQ-023 WAIT_BUSY, ut_busy=1: the next state SHALL be WAIT_DONE.
REQ-024 WAIT_BUSY, ut_busy=0: the counter SHALL increment; on reaching BUSY_TIMEOUT-1, timeout_err SHALL pulse for one cycle, the FSM SHALL return to IDLE, no ack SHALL issue and last_winner SHALL be unchanged (the request is retried).
REQ-025 WAIT_DONE: the FSM SHALL stay while ut_busy=1 and move to DONE on the first cycle ut_busy=0.
REQ-026 DONE: ackN SHALL be 1 for exactly one cycle (N=grant_id), last_winner SHALL be set to N, and the next state SHALL be IDLE.
REQ-027 Requester rule: a requester SHALL drop req on the edge after it sees ack; a req still high in IDLE is treated as a new request.
REQ-028 ut_data and grant_id SHALL be stable from LAUNCH through DONE; changes on dataN or reqN during that time SHALL be ignored.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle; ut_send SHALL never be high outside LAUNCH.
REQ-030 If ut_busy is already high at the DONE-to-IDLE transition, the next grant SHALL wait until it falls (REQ-017).

Reset
REQ-031 While reset=0, asynchronously: state=IDLE, ut_send=0, ut_data=8'h00, ack0=ack1=0, grant_id=0, active=0, timeout_err=0, last_winner=1, counter=0.
REQ-032 Reset asserted mid-transfer SHALL abort it with no ack; the FSM SHALL resume in IDLE on the first clk edge after reset returns high.

Verification
REQ-033 req0=1, data0=8'h8E, transmitter model with busy 3 cycles after send, held 20 cycles -> ut_send pulse 1 cycle after req, ut_data=8'h8E, ack0 pulse after busy falls, grant_id=0.
REQ-034 req0 and req1 both held continuously (dropped after ack and reasserted) -> grants alternate 0,1,0,1; acks never overlap.
REQ-035 Transmitter never raises busy, BUSY_TIMEOUT=8 -> timeout_err pulses 8 cycles after ut_send, no ack, the same requester relaunched.
REQ-036 ut_busy forced high while req1=1 in IDLE -> no ut_send until busy falls, then grant to requester 1.
REQ-037 reset driven low during WAIT_DONE -> all outputs zero immediately, no ack; after release, a pending req0 is granted normally.
REQ-038 data0 changes from 8'h41 to 8'h42 during WAIT_DONE -> ut_data stays 8'h41 until DONE.
